// File: rtl/wdg_counter_if.sv
// Watchdog counter bus: time base, control and threshold in; counter state and alarms out.
interface wdg_counter_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 wdg_tick;
    logic                 en;
    logic                 kick;
    logic [CNT_WIDTH-1:0] cmp;
    logic [CNT_WIDTH-1:0] cnt;
    logic [1:0]           stage;
    logic                 irq;
    logic                 wdg_rst;

    modport master (
        output wdg_tick, en, kick, cmp,
        input  cnt, stage, irq, wdg_rst
    );

    modport slave (
        input  wdg_tick, en, kick, cmp,
        output cnt, stage, irq, wdg_rst
    );
endinterface

// File: rtl/wdg_counter.sv
// Two-stage watchdog: counts tick edges up to cmp, raises irq (WARN), then a sticky
// system reset request (BITE). Kick restarts the timeout, en=0 parks in IDLE.
module wdg_counter #(
    parameter int CNT_WIDTH = 16
) (
    input logic          clk,
    input logic          res,
    wdg_counter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        WARN  = 2'd2,
        BITE  = 2'd3
    } state_e;

    localparam logic [CNT_WIDTH-1:0] ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 tick_prev_q;
    logic                 irq_q, wdg_rst_q;
    logic                 tick_ev;

    assign tick_ev = bus.wdg_tick & ~tick_prev_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = ZERO;
                if (bus.en) state_d = COUNT;
            end
            COUNT, WARN: begin
                // Priority: disable, then kick, then tick.
                if (!bus.en) begin
                    state_d = IDLE;
                    cnt_d   = ZERO;
                end else if (bus.kick) begin
                    state_d = COUNT;
                    cnt_d   = ZERO;
                end else if (tick_ev) begin
                    if (cnt_q >= bus.cmp) begin
                        cnt_d   = ZERO;
                        state_d = (state_q == COUNT) ? WARN : BITE;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
            BITE: begin
                cnt_d = ZERO;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = ZERO;
            end
        endcase
    end

    // tick_prev resets high so a tick held high through reset is not an edge.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= IDLE;
            cnt_q       <= ZERO;
            tick_prev_q <= 1'b1;
            irq_q       <= 1'b0;
            wdg_rst_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tick_prev_q <= bus.wdg_tick;
            irq_q       <= (state_d == WARN);
            wdg_rst_q   <= (state_d == BITE);
        end
    end

    assign bus.cnt     = cnt_q;
    assign bus.stage   = state_q;
    assign bus.irq     = irq_q;
    assign bus.wdg_rst = wdg_rst_q;
endmodule
